// File: rtl/hermes_pkt_tx.sv
// hermes_pkt_tx: packet transmitter for the Hermes NoC LOCAL port.
// Sends a header flit (destination), a size flit (payload length) and then
// the payload flits from an internal FIFO, using credit-based flow control.
// Optional statistics counters are enabled by defining HERMES_TX_STATS_EN.
module hermes_pkt_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [FLIT_WIDTH-1:0]   wr_data,
    output logic                    full,
    input  logic                    send,
    input  logic [FLIT_WIDTH/2-1:0] dest,
    input  logic [15:0]             len,
    output logic                    busy,
    output logic                    done,
    output logic [FLIT_WIDTH-1:0]   data_o,
    output logic                    tx,
    input  logic                    credit_i,
    output logic                    clock_tx
`ifdef HERMES_TX_STATS_EN
    ,
    output logic [31:0]             pkt_count,
    output logic [31:0]             flit_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_SIZE    = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]              state;
    logic [FLIT_WIDTH/2-1:0] dest_q;
    logic [15:0]             len_q;
    logic [15:0]             remaining;

    logic [FLIT_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             fifo_count;
    logic                    fifo_empty;
    logic                    xfer;
    logic                    push;
    logic                    pop;

    assign clock_tx   = clock;
    assign fifo_empty = (fifo_count == '0);
    assign full       = (fifo_count == FULL_COUNT);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign xfer       = tx && credit_i;
    assign pop        = (state == S_PAYLOAD) && xfer;
    // A full FIFO still accepts a write when the same edge frees a slot.
    assign push       = wr_en && (!full || pop);

    // Output flit selection: header, size, or FIFO head depending on state.
    always_comb begin
        data_o = '0;
        tx     = 1'b0;
        case (state)
            S_HEADER: begin
                data_o = FLIT_WIDTH'(dest_q);
                tx     = 1'b1;
            end
            S_SIZE: begin
                data_o = FLIT_WIDTH'(len_q);
                tx     = 1'b1;
            end
            S_PAYLOAD: begin
                if (!fifo_empty) begin
                    data_o = fifo_mem[rd_ptr];
                    tx     = 1'b1;
                end
            end
            default: begin
                data_o = '0;
                tx     = 1'b0;
            end
        endcase
    end

    // Payload storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Packet FSM: every advance waits for a flit transfer (tx && credit_i).
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (send) begin
                        dest_q <= dest;
                        len_q  <= len;
                        state  <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        state <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (xfer) begin
                        remaining <= len_q;
                        state     <= (len_q != 16'd0) ? S_PAYLOAD : S_DONE;
                    end
                end
                S_PAYLOAD: begin
                    if (pop) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HERMES_TX_STATS_EN
    // Packet and flit statistics, free-running and wrapping at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count  <= '0;
            flit_count <= '0;
        end else begin
            if (done) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (xfer) begin
                flit_count <= flit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hermes_pkt_tx.sv
// tb_hermes_pkt_tx: scoreboard bench for hermes_pkt_tx.
// Expected flits are queued as packets are launched and compared by a
// monitor whenever a transfer (tx && credit_i) is about to happen.
module tb_hermes_pkt_tx;

    localparam int FW = 32;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [FW-1:0] wr_data;
    logic          full;
    logic          send;
    logic [15:0]   dest;
    logic [15:0]   len;
    logic          busy;
    logic          done;
    logic [FW-1:0] data_o;
    logic          tx;
    logic          credit_i;
    logic          clock_tx;
`ifdef HERMES_TX_STATS_EN
    logic [31:0]   pkt_count;
    logic [31:0]   flit_count;
`endif

    int checks = 0;
    int errors = 0;
    int xfer_count = 0;
    logic [FW-1:0] exp_q [$];

    hermes_pkt_tx #(.FLIT_WIDTH(FW), .FIFO_DEPTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .send       (send),
        .dest       (dest),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .data_o     (data_o),
        .tx         (tx),
        .credit_i   (credit_i),
        .clock_tx   (clock_tx)
`ifdef HERMES_TX_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .flit_count (flit_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: sample between edges, compare each transfer.
    always @(negedge clock) begin
        if (reset === 1'b0 && tx === 1'b1 && credit_i === 1'b1) begin
            checks++;
            xfer_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_flit: got data_o=%h, expected no transfer", data_o);
            end else begin
                logic [FW-1:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("[TB] FAIL flit_data: got %h, expected %h", data_o, e);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_flit(input logic [FW-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_queue: %0d flits still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({tx, busy, done, full} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got tx/busy/done/full=%b, expected 0000", {tx, busy, done, full});
        end
        checks++;
        if (data_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h, expected 0", data_o);
        end
    endtask

    task automatic test_basic();
        push_flit(32'hAAAA_0001);
        push_flit(32'hBBBB_0002);
        push_flit(32'hCCCC_0003);
        exp_q.push_back(32'h0000_0101);
        exp_q.push_back(32'h0000_0003);
        exp_q.push_back(32'hAAAA_0001);
        exp_q.push_back(32'hBBBB_0002);
        exp_q.push_back(32'hCCCC_0003);
        credit_i = 1'b1;
        dest     = 16'h0101;
        len      = 16'd3;
        send     = 1'b1;
        tick();
        dest = 16'hFFFF;
        len  = 16'd9;
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) send = 1'b0;
            checks++;
            if (tx !== (k <= 5) || done !== (k == 6) || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d: got tx=%b done=%b busy=%b, expected tx=%b done=%b busy=1",
                         k, tx, done, busy, k <= 5, k == 6);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
        check_queue_empty("basic");
    endtask

    task automatic test_zero_len();
        exp_q.push_back(32'h0000_0203);
        exp_q.push_back(32'h0000_0000);
        dest = 16'h0203;
        len  = 16'd0;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (tx !== (k <= 2) || done !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL zero_len_cycle%0d: got tx=%b done=%b, expected tx=%b done=%b",
                         k, tx, done, k <= 2, k == 3);
            end
            tick();
        end
        check_queue_empty("zero_len");
    endtask

    task automatic test_credit_stall();
        int  start;
        bit  seen;
        push_flit(32'hDDDD_0004);
        exp_q.push_back(32'h0000_0310);
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'hDDDD_0004);
        start    = xfer_count;
        credit_i = 1'b1;
        dest     = 16'h0310;
        len      = 16'd1;
        send     = 1'b1;
        tick();
        send = 1'b0;
        tick();
        credit_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx !== 1'b1 || data_o !== 32'h0000_0001) begin
                errors++;
                $display("[TB] FAIL credit_hold%0d: got tx=%b data_o=%h, expected tx=1 data_o=00000001",
                         i, tx, data_o);
            end
            tick();
        end
        credit_i = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL credit_done: got no done pulse, expected one");
        end
        checks++;
        if (xfer_count - start != 3) begin
            errors++;
            $display("[TB] FAIL credit_count: got %0d transfers, expected 3", xfer_count - start);
        end
        tick();
        check_queue_empty("credit");
    endtask

    task automatic test_payload_stall();
        bit seen;
        exp_q.push_back(32'h0000_0405);
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'hEEEE_0005);
        exp_q.push_back(32'hFFFF_0006);
        credit_i = 1'b1;
        dest     = 16'h0405;
        len      = 16'd2;
        send     = 1'b1;
        tick();
        send = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL payload_gap%0d: got tx=%b busy=%b, expected tx=0 busy=1", i, tx, busy);
            end
            tick();
        end
        wr_en   = 1'b1;
        wr_data = 32'hEEEE_0005;
        tick();
        wr_data = 32'hFFFF_0006;
        tick();
        wr_en = 1'b0;
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL payload_done: got no done pulse, expected one");
        end
        tick();
        check_queue_empty("payload");
    endtask

    task automatic test_fifo_full();
        bit seen;
        exp_q.push_back(32'h0000_0506);
        exp_q.push_back(32'h0000_0011);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_early: got full=%b, expected 0", full);
                end
            end
            exp_q.push_back(32'h1000_0000 + 32'(i));
            push_flit(32'h1000_0000 + 32'(i));
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_set: got full=%b, expected 1", full);
        end
        push_flit(32'hDEAD_BEEF);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_drop: got full=%b, expected 1", full);
        end
        exp_q.push_back(32'h5555_0017);
        credit_i = 1'b1;
        dest     = 16'h0506;
        len      = 16'd17;
        send     = 1'b1;
        tick();
        send = 1'b0;
        tick();
        tick();
        wr_en   = 1'b1;
        wr_data = 32'h5555_0017;
        tick();
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_pushpop: got full=%b, expected 1", full);
        end
        wait_done(40, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL full_done: got no done pulse, expected one");
        end
        tick();
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drained: got full=%b, expected 0", full);
        end
        check_queue_empty("full");
    endtask

    task automatic test_reset_mid();
        bit seen;
        push_flit(32'h7777_0001);
        push_flit(32'h7777_0002);
        push_flit(32'h7777_0003);
        exp_q.push_back(32'h0000_0607);
        exp_q.push_back(32'h0000_0003);
        credit_i = 1'b1;
        dest     = 16'h0607;
        len      = 16'd3;
        send     = 1'b1;
        tick();
        send = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({tx, busy, done, full} !== 4'b0000 || data_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got tx/busy/done/full=%b data_o=%h, expected 0000 0",
                     {tx, busy, done, full}, data_o);
        end
`ifdef HERMES_TX_STATS_EN
        checks++;
        if (pkt_count !== 32'd0 || flit_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: got pkt=%0d flit=%0d, expected 0 0", pkt_count, flit_count);
        end
`endif
        check_queue_empty("reset_mid");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_quiet%0d: got tx=%b done=%b, expected 0 0", i, tx, done);
            end
            tick();
        end
        exp_q.push_back(32'h0000_0708);
        exp_q.push_back(32'h0000_0001);
        dest = 16'h0708;
        len  = 16'd1;
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        tick();
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_fifo_empty: got tx=%b busy=%b, expected tx=0 busy=1", tx, busy);
        end
        exp_q.push_back(32'h8888_0001);
        push_flit(32'h8888_0001);
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL reset_after_done: got no done pulse, expected one");
        end
        tick();
        check_queue_empty("reset_after");
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        send     = 1'b0;
        dest     = '0;
        len      = '0;
        credit_i = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_credit_stall();
        test_payload_stall();
        test_fifo_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
